// File: rtl/scope_capture_pkg.sv
// Shared definitions for the scope capture path and its neighbours (sndgen, vga).
package scope_capture_pkg;

    localparam int SAMPLE_W = 4;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port 2*DEPTH x SAMPLE_W sample memory; the array has no reset,
// only the registered read output does.
module scope_ram
    import scope_capture_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW:0]         wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic [AW:0]         rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [2*DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scope_capture.sv
// Trigger-aligned, double-buffered waveform capture feeding the VGA scope view.
// The display bank flips only on frame_start while HOLDing a finished capture.
module scope_capture
    import scope_capture_pkg::*;
#(
    parameter int                  DEPTH      = 256,
    parameter int                  AW         = 8,
    parameter logic [SAMPLE_W-1:0] TRIG_LEVEL = 4'd8,
    parameter int                  TIMEOUT    = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample_ena,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                frame_start,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                disp_bank,
    output logic                triggered,
    output logic                busy
);

    localparam int          TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_TC = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_t                state;
    logic [AW-1:0]         wr_ptr;
    logic [TW-1:0]         tmo_cnt;
    logic [SAMPLE_W-1:0]   prev_sample;
    logic                  trig_flag;
    logic                  trig_cond;
    logic                  start;
    logic                  wr_en;
    logic                  cap_last;

    always_comb begin
        trig_cond = (prev_sample < TRIG_LEVEL) && (sample >= TRIG_LEVEL);
        start     = (state == ARMED) && sample_ena && (trig_cond || (tmo_cnt == TMO_TC));
        wr_en     = start || ((state == CAPTURE) && sample_ena);
        cap_last  = (state == CAPTURE) && sample_ena && (wr_ptr == PTR_LAST);
    end

    // busy is registered from the next state so it lines up with the state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARMED;
            wr_ptr      <= '0;
            tmo_cnt     <= '0;
            prev_sample <= '0;
            trig_flag   <= 1'b0;
            disp_bank   <= 1'b0;
            triggered   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (sample_ena) prev_sample <= sample;
            case (state)
                ARMED: begin
                    busy <= 1'b1;
                    if (sample_ena) begin
                        if (tmo_cnt != TMO_TC) tmo_cnt <= tmo_cnt + 1'b1;
                        if (start) begin
                            wr_ptr    <= AW'(1);
                            trig_flag <= trig_cond;
                            state     <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    busy <= 1'b1;
                    if (sample_ena) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (cap_last) begin
                            state <= HOLD;
                            busy  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    busy <= 1'b0;
                    if (frame_start) begin
                        disp_bank <= ~disp_bank;
                        triggered <= trig_flag;
                        tmo_cnt   <= '0;
                        state     <= ARMED;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= ARMED;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    scope_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({~disp_bank, wr_ptr}),
        .wr_data (sample),
        .rd_addr ({disp_bank, rd_addr}),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: ramp trigger, auto trigger, ignored and
// simultaneous frame_start, async reset mid-capture, read isolation.
module tb_scope_capture;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sample_ena = 1'b0;
    logic [3:0] sample = '0;
    logic       frame_start = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       disp_bank;
    logic       triggered;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    scope_capture dut (
        .clock       (clock),
        .reset       (reset),
        .sample_ena  (sample_ena),
        .sample      (sample),
        .frame_start (frame_start),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .disp_bank   (disp_bank),
        .triggered   (triggered),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs applied at negedge, outputs observed 1 time unit after posedge.
    task automatic step(input logic e, input logic [3:0] s, input logic f, input logic [7:0] a);
        @(negedge clock);
        sample_ena  = e;
        sample      = s;
        frame_start = f;
        rd_addr     = a;
        @(posedge clock);
        #1;
        sample_ena  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [3:0] exp);
        step(1'b0, 4'd0, 1'b0, a);
        chk(tag, {28'd0, rd_data}, {28'd0, exp});
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] v;

        // Reset values
        #12;
        chk("rst_rd_data",   {28'd0, rd_data}, 32'd0);
        chk("rst_disp_bank", {31'd0, disp_bank}, 32'd0);
        chk("rst_triggered", {31'd0, triggered}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 4'd0, 1'b0, 8'd0);
        chk("armed_busy", {31'd0, busy}, 32'd1);

        // Ramp trigger, with an ignored frame_start during CAPTURE
        for (int i = 0; i < 264; i++) begin
            v = 4'(i);
            step(1'b1, v, (i == 100), 8'd0);
            if (i == 100) begin
                chk("early_fs_bank", {31'd0, disp_bank}, 32'd0);
                chk("early_fs_busy", {31'd0, busy}, 32'd1);
            end
            if (i == 262) chk("ramp_busy_before_end", {31'd0, busy}, 32'd1);
        end
        chk("ramp_hold_busy", {31'd0, busy}, 32'd0);
        chk("ramp_hold_bank", {31'd0, disp_bank}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 8'd0);
        chk("ramp_swap_bank", {31'd0, disp_bank}, 32'd1);
        chk("ramp_swap_trig", {31'd0, triggered}, 32'd1);
        chk("ramp_swap_busy", {31'd0, busy}, 32'd1);
        rd_chk("ramp_a0",   8'd0,   4'd8);
        rd_chk("ramp_a7",   8'd7,   4'd15);
        rd_chk("ramp_a8",   8'd8,   4'd0);
        rd_chk("ramp_a255", 8'd255, 4'd7);

        // Auto trigger on tick TIMEOUT; sweep reads of bank 1 while bank 0 fills
        for (int t = 1; t <= 4351; t++) begin
            a = 8'(t);
            v = (t == 4096) ? 4'd5 : 4'd3;
            step(1'b1, v, 1'b0, a);
            if (t >= 4096) chk("iso_read", {28'd0, rd_data}, {28'd0, 4'(a + 8'd8)});
            if (t == 4095) chk("auto_armed_busy", {31'd0, busy}, 32'd1);
            if (t == 4350) chk("auto_busy_before_end", {31'd0, busy}, 32'd1);
        end
        chk("auto_hold_busy", {31'd0, busy}, 32'd0);

        // Simultaneous frame_start and a would-be crossing in HOLD
        step(1'b1, 4'd7, 1'b0, 8'd0);
        step(1'b1, 4'd9, 1'b1, 8'd0);
        chk("sim_swap_bank", {31'd0, disp_bank}, 32'd0);
        chk("sim_swap_trig", {31'd0, triggered}, 32'd0);
        chk("sim_swap_busy", {31'd0, busy}, 32'd1);
        rd_chk("auto_a0",   8'd0,   4'd5);
        rd_chk("auto_a1",   8'd1,   4'd3);
        rd_chk("auto_a128", 8'd128, 4'd3);
        rd_chk("auto_a255", 8'd255, 4'd3);

        step(1'b1, 4'd2, 1'b0, 8'd0);
        step(1'b1, 4'd12, 1'b0, 8'd0);
        for (int i = 0; i < 255; i++) begin
            v = 4'(i);
            step(1'b1, v, 1'b0, 8'd0);
            if (i == 253) chk("next_busy_before_end", {31'd0, busy}, 32'd1);
        end
        chk("next_hold_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 8'd0);
        chk("next_swap_bank", {31'd0, disp_bank}, 32'd1);
        chk("next_swap_trig", {31'd0, triggered}, 32'd1);
        rd_chk("next_a0",   8'd0,   4'd12);
        rd_chk("next_a1",   8'd1,   4'd0);
        rd_chk("next_a20",  8'd20,  4'd3);
        rd_chk("next_a255", 8'd255, 4'd14);

        // Reset asserted with wr_ptr at 100
        step(1'b1, 4'd0, 1'b0, 8'd0);
        step(1'b1, 4'd8, 1'b0, 8'd0);
        for (int i = 0; i < 99; i++) step(1'b1, 4'd4, 1'b0, 8'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_bank",    {31'd0, disp_bank}, 32'd0);
        chk("midrst_trig",    {31'd0, triggered}, 32'd0);
        chk("midrst_busy",    {31'd0, busy}, 32'd0);
        chk("midrst_rd_data", {28'd0, rd_data}, 32'd0);
        #3;
        reset = 1'b0;

        step(1'b1, 4'd5, 1'b0, 8'd0);
        step(1'b1, 4'd10, 1'b0, 8'd0);
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 4'd1, 1'b0, 8'd0);
            if (i == 253) chk("fresh_busy_before_end", {31'd0, busy}, 32'd1);
        end
        chk("fresh_hold_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 8'd0);
        chk("fresh_swap_bank", {31'd0, disp_bank}, 32'd1);
        chk("fresh_swap_trig", {31'd0, triggered}, 32'd1);
        rd_chk("fresh_a0",   8'd0,   4'd10);
        rd_chk("fresh_a1",   8'd1,   4'd1);
        rd_chk("fresh_a255", 8'd255, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Oscilloscope-style capture stage between the sound generator and the VGA renderer.
- Records the 4-bit mixed audio sample stream into a double-buffered sample memory, aligned to a rising-edge trigger.
- The VGA side reads a stable, previously completed waveform by column address; banks swap only at frame boundaries, so the display never tears.

Parameters:
- DEPTH, 256: samples per capture bank; power of two; also the display column count.
- AW, 8: address width, equal to clog2(DEPTH).
- TRIG_LEVEL, 8: 4-bit trigger threshold.
- TIMEOUT, 4096: sample_ena ticks spent in ARMED before a forced (auto) trigger.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_ena  in  1  one-cycle strobe at the sample rate; qualifies sample
- sample  in  4  current audio sample, unsigned
- frame_start  in  1  one-cycle pulse at the start of each VGA frame
- rd_addr  in  AW  display column to read
- rd_data  out  4  sample at rd_addr in the display bank; 1-cycle latency
- disp_bank  out  1  bank currently presented to the display
- triggered  out  1  the last completed capture came from a real trigger (0 = auto)
- busy  out  1  capture FSM is not IDLE/HOLD

Behaviour:
- Reset values: rd_data=0, disp_bank=0, triggered=0, busy=0.
- Reset state: FSM=ARMED, write bank = ~disp_bank = 1, prev_sample=0, wr_ptr=0, timeout counter=0. Memory contents are undefined after reset; the bench must not check them before the first swap.
- prev_sample latches sample on every sample_ena.
- All write-side state advances only on cycles where sample_ena=1.
- Trigger condition: prev_sample < TRIG_LEVEL and sample >= TRIG_LEVEL, both unsigned 4-bit.
- FSM states:
  - ARMED: busy=1. On sample_ena, increment the timeout counter.
    - If the trigger condition is true: write sample to wr_ptr=0, set wr_ptr=1, trig_flag=1, go to CAPTURE.
    - Else if the counter reaches TIMEOUT-1 on this tick: same actions but trig_flag=0 (auto).
  - CAPTURE: busy=1. On sample_ena, write sample at wr_ptr and increment wr_ptr.
    - When the write at DEPTH-1 completes, go to HOLD and reset wr_ptr to 0.
    - Each capture holds exactly DEPTH consecutive samples; sample[0] is the trigger sample.
  - HOLD: busy=0. Waits for frame_start.
    - On frame_start: disp_bank <= write bank, write bank <= old disp_bank, triggered <= trig_flag, timeout counter <= 0, go to ARMED. All of this happens on the same edge.
- frame_start in ARMED or CAPTURE is ignored: no swap, and the display keeps its old bank.
- sample_ena and frame_start in the same cycle while in HOLD: the swap takes priority. The sample is not a trigger candidate that cycle but still updates prev_sample.
- Read port: rd_data is registered on every clock edge as mem[disp_bank][rd_addr]. Latency is exactly 1 cycle.
  - After a swap edge, reads issued on the next cycle return the new bank.
  - Reads never touch the write bank, so there are no read/write collisions.
- wr_ptr is AW bits wide and wraps naturally. The timeout counter is clog2(TIMEOUT) bits and saturates at its terminal count.
- Reset asserted mid-capture: immediate return to reset state. disp_bank returns to 0; partial data is discarded.
- Memory: 2*DEPTH x 4 bits with one synchronous write port and one synchronous read port. No reset on the array.

Decomposition:
- Shared package holds the FSM state encoding constants (ARMED, CAPTURE, HOLD) and the SAMPLE_W=4 constant, which sndgen and vga also use.
- One natural sub-module: scope_ram, a simple dual-port 2*DEPTH x 4 memory (write enable/address/data, registered read), so it can be mapped to block RAM or latches.

Test Plan:
- Ramp trigger: after reset, feed a ramp 0..15 repeating, one sample per sample_ena, then pulse frame_start after HOLD is reached -> disp_bank=1, triggered=1, rd_addr=0 gives 8 the next cycle, rd_addr=7 gives 15, rd_addr=8 gives 0.
- Auto trigger: constant sample=3 for TIMEOUT ticks -> capture starts on tick TIMEOUT. After the frame_start swap, triggered=0 and every address reads 3.
- Ignored early frame_start: pulse frame_start during CAPTURE -> disp_bank unchanged and busy stays 1. The swap happens only at the first frame_start after HOLD.
- Simultaneous events: frame_start and sample_ena together in HOLD with prev_sample=7, sample=9 -> swap occurs, FSM=ARMED, no trigger that cycle. The next crossing triggers normally.
- Reset mid-capture: assert reset at wr_ptr=100 -> outputs return to reset values within the same cycle (asynchronous). A fresh capture completes DEPTH samples afterward.
- Read latency and bank isolation: while capturing into bank 0, sweep rd_addr every cycle -> rd_data matches the bank 1 contents with exactly 1-cycle latency and is unaffected by the ongoing writes.
